// File: rtl/comm_pkg.sv
// Shared constants, opcodes and FSM state type for the console pin-mux command controller.
package comm_pkg;

    localparam logic [2:0] COMM_READ_PIN_MAP      = 3'd0;
    localparam logic [2:0] COMM_WRITE_PIN_MAP     = 3'd1;
    localparam logic [2:0] COMM_READ_ENABLE_MASK  = 3'd2;
    localparam logic [2:0] COMM_WRITE_ENABLE_MASK = 3'd3;

    localparam int unsigned N_OUT     = 16;
    localparam int unsigned N_IN      = 4;
    localparam int unsigned PIN_SEL_W = 2;

    localparam int unsigned PIN_MAP_W       = N_OUT * PIN_SEL_W;
    localparam int unsigned PIN_MAP_LEN     = PIN_MAP_W / 8;
    localparam int unsigned ENABLE_MASK_LEN = N_OUT / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX_PAYLOAD,
        ST_TX_LOAD,
        ST_TX_WAIT
    } comm_state_e;

    // Index of the final byte for the selected register.
    function automatic logic [1:0] last_idx(input logic is_pm);
        return is_pm ? 2'(PIN_MAP_LEN - 1) : 2'(ENABLE_MASK_LEN - 1);
    endfunction

endpackage

// File: rtl/comm_rx_timeout.sv
// Inter-byte idle counter for payload reception; expired_c is high while the limit is reached.
module comm_rx_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired_c
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || clear) begin
            count <= '0;
        end else if (!expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = run && (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/comm_ctrl.sv
// Command controller: decodes UART opcodes, commits pin_map / enable_mask, streams responses.
// Optional payload timeout enabled by defining COMM_TIMEOUT_EN.
module comm_ctrl
    import comm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic [31:0] pin_map,
    output logic [15:0] enable_mask,
    output logic        busy,
    output logic        err
);
    comm_state_e state;
    logic [1:0]  cnt;
    logic        is_pm;
    logic [23:0] shadow;
    logic [31:0] tx_word;
    logic        expired_c;

`ifdef COMM_TIMEOUT_EN
    comm_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state == ST_RX_PAYLOAD),
        .clear     (rx_ready),
        .expired_c (expired_c)
    );
`else
    assign expired_c = 1'b0;
`endif

    assign tx_word = is_pm ? pin_map : {16'h0000, enable_mask};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            is_pm       <= 1'b0;
            shadow      <= '0;
            pin_map     <= '0;
            enable_mask <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_ready) begin
                        cnt <= '0;
                        case (rx_data[2:0])
                            COMM_READ_PIN_MAP: begin
                                is_pm <= 1'b1;
                                state <= ST_TX_LOAD;
                                busy  <= 1'b1;
                            end
                            COMM_WRITE_PIN_MAP: begin
                                is_pm <= 1'b1;
                                state <= ST_RX_PAYLOAD;
                                busy  <= 1'b1;
                            end
                            COMM_READ_ENABLE_MASK: begin
                                is_pm <= 1'b0;
                                state <= ST_TX_LOAD;
                                busy  <= 1'b1;
                            end
                            COMM_WRITE_ENABLE_MASK: begin
                                is_pm <= 1'b0;
                                state <= ST_RX_PAYLOAD;
                                busy  <= 1'b1;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                // Byte acceptance takes priority over a simultaneous expiry.
                ST_RX_PAYLOAD: begin
                    if (rx_ready) begin
                        if (cnt == last_idx(is_pm)) begin
                            if (is_pm) pin_map <= {rx_data, shadow[23:0]};
                            else       enable_mask <= {rx_data, shadow[7:0]};
                            cnt   <= '0;
                            state <= ST_TX_LOAD;
                        end else begin
                            case (cnt)
                                2'd0:    shadow[7:0]   <= rx_data;
                                2'd1:    shadow[15:8]  <= rx_data;
                                default: shadow[23:16] <= rx_data;
                            endcase
                            cnt <= cnt + 2'd1;
                        end
                    end else if (expired_c) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_TX_LOAD: begin
                    tx_data  <= tx_word[{cnt, 3'b000} +: 8];
                    tx_start <= 1'b1;
                    state    <= ST_TX_WAIT;
                end
                // A done coincident with our own start pulse belongs to no byte of ours.
                ST_TX_WAIT: begin
                    if (tx_done && !tx_start) begin
                        if (cnt == last_idx(is_pm)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt   <= cnt + 2'd1;
                            state <= ST_TX_LOAD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comm_ctrl.sv
// Scoreboard bench for comm_ctrl: random/directed commands vs. a register-level model.
module tb_comm_ctrl;
    localparam int unsigned TO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [31:0] pin_map;
    logic [15:0] enable_mask;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;
    int exp_err = 0;
    int tx_seen = 0;
    logic [7:0]  exp_tx_q[$];
    logic [31:0] m_pm = 32'h0;
    logic [15:0] m_em = 16'h0;

    bit         pend = 1'b0;
    logic [7:0] held = 8'h00;
    int         dly = 0;

    comm_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .pin_map     (pin_map),
        .enable_mask (enable_mask),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor plus UART transmitter stand-in, both sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend    = 1'b0;
            tx_done = 1'b0;
        end else begin
            if (err) begin
                chk("err_expected", 32'(exp_err > 0), 32'd1);
                if (exp_err > 0) exp_err--;
            end
            tx_done = 1'b0;
            if (tx_start) begin
                tx_seen++;
                chk("tx_start_while_pending", 32'(pend), 32'd0);
                if (exp_tx_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                else chk("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
                pend    = 1'b1;
                held    = tx_data;
                dly     = $urandom_range(2, 6);
                tx_done = ($urandom_range(0, 1) == 1);
            end else if (pend) begin
                chk("tx_data_stable", 32'(tx_data), 32'(held));
                if (dly == 0) begin
                    tx_done = 1'b1;
                    pend    = 1'b0;
                end else begin
                    dly--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk("cmd_completes", 32'(busy), 32'd0);
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [31:0] pay,
                           input int stall_idx, input int stall_len);
        bit          pm = 1'b0;
        bit          wr = 1'b0;
        bit          known = 1'b1;
        int          len;
        logic [31:0] old_val;
        logic [31:0] new_val;
        logic [31:0] cur;
        case (op[2:0])
            3'd0: pm = 1'b1;
            3'd1: begin pm = 1'b1; wr = 1'b1; end
            3'd2: pm = 1'b0;
            3'd3: wr = 1'b1;
            default: known = 1'b0;
        endcase
        if (!known) begin
            exp_err++;
            send(op);
            chk("busy_after_bad_op", 32'(busy), 32'd0);
            tick();
            tick();
            chk("err_pulse_seen", 32'(exp_err), 32'd0);
            chk("busy_stays_idle", 32'(busy), 32'd0);
            return;
        end
        len     = pm ? 4 : 2;
        old_val = pm ? m_pm : {16'h0, m_em};
        if (wr) begin
            if (pm) m_pm = pay;
            else    m_em = pay[15:0];
        end
        new_val = pm ? m_pm : {16'h0, m_em};
        for (int i = 0; i < len; i++) exp_tx_q.push_back(new_val[8*i +: 8]);
        send(op);
        chk("busy_after_op", 32'(busy), 32'd1);
        if (wr) begin
            for (int i = 0; i < len; i++) begin
                repeat ((i == stall_idx) ? stall_len : $urandom_range(0, 3)) tick();
                cur = pm ? pin_map : {16'h0, enable_mask};
                chk("no_partial_commit", cur, old_val);
                send(pay[8*i +: 8]);
            end
            cur = pm ? pin_map : {16'h0, enable_mask};
            chk("commit_at_last_edge", cur, new_val);
        end
        if ($urandom_range(0, 1) == 1) send(8'($urandom));
        wait_idle();
        chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
        chk("pin_map_model", pin_map, m_pm);
        chk("enable_mask_model", {16'h0, enable_mask}, {16'h0, m_em});
    endtask

    initial begin
        int          n;
        int          seen;
        logic [31:0] old;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pin_map", pin_map, 32'h0);
        chk("rst_enable_mask", {16'h0, enable_mask}, 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        tick();

        run_cmd(8'h00, 32'h0, -1, 0);
        run_cmd(8'h03, 32'h0000CDAB, -1, 0);
        run_cmd(8'h02, 32'h0, -1, 0);
        run_cmd(8'h01, 32'h89ABCDEF, -1, 0);
        run_cmd(8'h00, 32'h0, -1, 0);
        run_cmd(8'h00, 32'h0, -1, 0);
        run_cmd(8'h05, 32'h0, -1, 0);
        run_cmd(8'h02, 32'h0, -1, 0);
        run_cmd(8'hFB, 32'h00003C5A, -1, 0);

`ifdef COMM_TIMEOUT_EN
        old = m_pm;
        send(8'h01);
        send(8'h11);
        send(8'h22);
        exp_err++;
        repeat (TO + 3) tick();
        chk("timeout_err_seen", 32'(exp_err), 32'd0);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_pin_map", pin_map, old);
        run_cmd(8'h00, 32'h0, -1, 0);
`else
        old = m_pm;
        run_cmd(8'h01, 32'h13572468, 2, 60);
        chk("stalled_write_changed", 32'(pin_map != old), 32'd1);
`endif

        for (int k = 0; k < 40; k++) run_cmd(8'($urandom), $urandom, -1, 0);
        run_cmd(8'h01, 32'hA5A5F00F, -1, 0);

        // Reset in the middle of a read response.
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(m_pm[8*i +: 8]);
        send(8'h00);
        n = 0;
        while (!tx_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test_tx_started", 32'(tx_start), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pin_map", pin_map, 32'h0);
        chk("async_rst_enable_mask", {16'h0, enable_mask}, 32'h0);
        chk("async_rst_tx_data", 32'(tx_data), 32'h0);
        chk("async_rst_tx_start", 32'(tx_start), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        exp_tx_q.delete();
        m_pm = 32'h0;
        m_em = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = tx_seen;
        repeat (20) tick();
        chk("no_tx_after_reset", 32'(tx_seen - seen), 32'd0);
        run_cmd(8'h00, 32'h0, -1, 0);
        run_cmd(8'h02, 32'h0, -1, 0);

        chk("final_err_balance", 32'(exp_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comm_ctrl.md
# comm_ctrl

Command controller for the console pin mux. Consumes bytes from the host-side UART receiver, decodes 3-bit opcodes, and collects little-endian payloads. Commits the pin map and output-enable mask registers that drive the mux datapath, then sequences the multi-byte response through the UART transmitter. Sits between `uart_rx`/`uart_tx` and the output-pin mux inside `comm`.

## Interface
- `TIMEOUT_CYCLES`, default 4096: idle clocks allowed between payload bytes before abort; only used with `COMM_TIMEOUT_EN`.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_ready`  in  1  one-cycle pulse; `rx_data` valid.
- `rx_data`  in  8  received byte.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until `tx_done`.
- `tx_start`  out  1  one-cycle request to `uart_tx`.
- `tx_done`  in  1  transmitter finished the current byte (stop bit sent).
- `pin_map`  out  32  2 bits per output: bits [2k+1:2k] select the input pin for output k.
- `enable_mask`  out  16  bit k = 1 drives output k; 0 tri-states it.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse on unknown opcode or payload timeout.

## Operation
- Opcode is `rx_data[2:0]`; `rx_data[7:3]` are ignored. Encodings:
  - READ_PIN_MAP = 0: 4 response bytes.
  - WRITE_PIN_MAP = 1: 4 payload bytes, then 4 response bytes.
  - READ_ENABLE_MASK = 2: 2 response bytes.
  - WRITE_ENABLE_MASK = 3: 2 payload bytes, then 2 response bytes.
  - Opcodes 4–7 are unknown: `err` pulses and the state stays IDLE.
- States:
  - IDLE: on `rx_ready`, decode. Reads go to TX_LOAD. Writes go to RX_PAYLOAD with the byte counter cleared.
  - RX_PAYLOAD: each `rx_ready` stores `rx_data` into shadow bits [8n+7:8n], where n is the byte index. On the last byte, the shadow commits to `pin_map` or `enable_mask` at that same edge, all bits at once, and the state goes to TX_LOAD.
  - TX_LOAD: loads `tx_data` with byte n of the committed register, LSB byte first, and asserts `tx_start` for one cycle. Goes to TX_WAIT.
  - TX_WAIT: on `tx_done`, if n is the last byte go to IDLE; otherwise increment n and go to TX_LOAD.
- Write commands echo the newly committed value. Reads return the current value.
- `rx_ready` during TX_LOAD or TX_WAIT: the byte is discarded, with no error.
- Partially received payloads never modify the outputs.
- Byte counter is 2 bits wide and compared against (length−1). It never wraps past the command length.

## Timing
- Reset values: `pin_map`=0, `enable_mask`=0, `tx_data`=0, `tx_start`=0, `busy`=0, `err`=0, state IDLE.
- Reset asserted mid-command aborts immediately. Registers return to 0 and no further `tx_start` is issued.
- `tx_start` rises one clock after the edge that samples a read opcode or the final payload byte.
- Between bytes, `tx_start` for byte n+1 rises one clock after the `tx_done` of byte n is sampled.
- `pin_map` and `enable_mask` change exactly at the final-payload edge. The mux sees the new value in the next cycle.
- `tx_done` arriving in the same cycle as `tx_start` is ignored; only `tx_done` sampled in TX_WAIT counts.
- `err` is registered and asserted for exactly one cycle.

## Configuration
- `COMM_TIMEOUT_EN` defined:
  - A counter clears on entry to RX_PAYLOAD and on each `rx_ready`.
  - When it reaches `TIMEOUT_CYCLES`, the shadow is discarded, `err` pulses, and the state goes to IDLE with the registers unchanged.
  - `rx_ready` in the same cycle as expiry wins: the byte is accepted and the counter is cleared.
- Not defined: RX_PAYLOAD waits indefinitely. The counter logic is absent and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `comm_pkg` holds:
  - opcode constants COMM_READ_PIN_MAP, COMM_WRITE_PIN_MAP, COMM_READ_ENABLE_MASK, COMM_WRITE_ENABLE_MASK;
  - the state enum;
  - N_OUT=16, N_IN=4, PIN_SEL_W=2;
  - response lengths.
- One sub-module, `comm_rx_timeout` (counter + expiry pulse), instantiated only under `COMM_TIMEOUT_EN`.

## Test plan
- After reset, send 0x00 → response bytes 00 00 00 00; `pin_map`=0.
- Send 0x03, then AB, CD → `enable_mask`=16'hCDAB on the last payload edge; echo AB CD. A following 0x02 returns AB CD.
- Send 0x01, then EF CD AB 89 → `pin_map`=32'h89ABCDEF; echo EF CD AB 89. The two repeated reads return the same.
- Send 0x05 → `err` pulses once, no `tx_start`, `busy` stays 0. A following 0x02 responds normally.
- Send 0x01 and two payload bytes, then:
  - with `COMM_TIMEOUT_EN`, idle TIMEOUT_CYCLES+1 clocks → `err` pulses and `pin_map` is unchanged;
  - without it, send the remaining bytes → commit happens.
- Drop `rst_n` during TX_WAIT of a 0x00 read → all outputs 0 asynchronously; no `tx_start` after release until a new opcode arrives.
